// File: rtl/coin_score_tracker.sv
// Purpose: per-frame Mario vs 3 coins + goomba collision scan with sticky flags and a saturating score; the goomba check exists only with GOOMBA_EN defined.
// Latency: edge in cycle N -> SCAN N+1..N+4 (one object per Clk), DONE N+5, idle from N+6; each award is visible the Clk after its SCAN cycle.
// Backpressure: none; a frame_clk edge arriving while busy is dropped, not queued.
module coin_score_tracker #(
  parameter int COIN_PTS   = 1,
  parameter int GOOMBA_PTS = 5,
  parameter int SCORE_MAX  = 999
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] Ball_size_X,
  input  logic [9:0] Ball_size_Y,
  input  logic [5:0] logx,
  input  logic       mario_falling,
  output logic       is_coin1_detect,
  output logic       is_coin2_detect,
  output logic       is_coin3_detect,
  output logic       is_goomba1_d1,
  output logic [9:0] score,
  output logic       mario_hit,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       frame_clk_d;
  logic       frame_edge;
  logic       snap_en;

  // Snapshot of Mario's box, held for the whole scan so a mid-scan input change cannot split a frame.
  logic [11:0] snap_wx;
  logic [11:0] snap_sx;
  logic [11:0] snap_y;
  logic [11:0] snap_sy;

  // Mario box edges (12 bits so the right/bottom sums never wrap) and current object box.
  logic [11:0] m_l, m_r, m_t, m_b;
  logic [11:0] o_l, o_r, o_t, o_b;
  logic        hit;

  assign frame_edge = frame_clk & ~frame_clk_d;
  assign busy       = (state != IDLE);

  function automatic logic [9:0] sat_add(input logic [9:0] s, input int pts);
    int sum;
    sum = int'({22'd0, s}) + pts;
    if (sum > SCORE_MAX) sat_add = 10'(SCORE_MAX);
    else                 sat_add = 10'(sum);
  endfunction

  // Frame strobe delay register for rising-edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) frame_clk_d <= 1'b0;
    else       frame_clk_d <= frame_clk;
  end

  // Scan state register and object index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: IDLE waits for an edge, SCAN walks idx 0..3, DONE returns to IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_en   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_edge) begin
          state_nxt = SCAN;
          idx_nxt   = 2'd0;
          snap_en   = 1'b1;
        end
      end
      SCAN: begin
        if (idx == 2'd3) state_nxt = DONE;
        else             idx_nxt   = idx + 2'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch Mario's position in world X (screen X plus scroll) at scan start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap_wx <= 12'd0;
      snap_sx <= 12'd0;
      snap_y  <= 12'd0;
      snap_sy <= 12'd0;
    end else if (snap_en) begin
      snap_wx <= {2'd0, BallX} + {6'd0, logx};
      snap_sx <= {2'd0, Ball_size_X};
      snap_y  <= {2'd0, BallY};
      snap_sy <= {2'd0, Ball_size_Y};
    end
  end

  // Mario box edges; left/top clamp to 0 rather than wrapping when the half-extent exceeds the centre.
  always_comb begin
    m_l = (snap_wx >= snap_sx) ? (snap_wx - snap_sx) : 12'd0;
    m_r = snap_wx + snap_sx;
    m_t = (snap_y >= snap_sy) ? (snap_y - snap_sy) : 12'd0;
    m_b = snap_y + snap_sy;
  end

  // Object box selected by scan index (world X, screen Y, exclusive bounds).
  always_comb begin
    o_l = 12'd0;
    o_r = 12'd0;
    o_t = 12'd0;
    o_b = 12'd0;
    case (idx)
      2'd0: begin o_l = 12'd230; o_r = 12'd245; o_t = 12'd278; o_b = 12'd298; end
      2'd1: begin o_l = 12'd260; o_r = 12'd275; o_t = 12'd278; o_b = 12'd298; end
      2'd2: begin o_l = 12'd140; o_r = 12'd155; o_t = 12'd378; o_b = 12'd398; end
      default: begin o_l = 12'd400; o_r = 12'd430; o_t = 12'd375; o_b = 12'd410; end
    endcase
  end

  // Strict overlap: boxes that only touch along an edge do not collide.
  assign hit = (state == SCAN) && (m_l < o_r) && (m_r > o_l) && (m_t < o_b) && (m_b > o_t);

`ifdef GOOMBA_EN
  logic snap_fall;

  // Direction of travel is captured with the position so stomp vs side hit matches the scanned frame.
  always_ff @(posedge Clk) begin
    if (Reset)        snap_fall <= 1'b0;
    else if (snap_en) snap_fall <= mario_falling;
  end

  // Goomba: stomp while falling defeats it, any other contact pulses mario_hit once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      is_goomba1_d1 <= 1'b0;
      mario_hit     <= 1'b0;
    end else begin
      mario_hit <= 1'b0;
      if (hit && idx == 2'd3 && !is_goomba1_d1) begin
        if (snap_fall) is_goomba1_d1 <= 1'b1;
        else           mario_hit     <= 1'b1;
      end
    end
  end
`else
  // idx3 still takes its SCAN cycle, but nothing is checked there.
  logic unused_fall;
  assign unused_fall   = mario_falling;
  assign is_goomba1_d1 = 1'b0;
  assign mario_hit     = 1'b0;
`endif

  // Coin flags and score; at most one object awards per Clk so a single adder suffices.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      is_coin1_detect <= 1'b0;
      is_coin2_detect <= 1'b0;
      is_coin3_detect <= 1'b0;
      score           <= 10'd0;
    end else if (hit) begin
      case (idx)
        2'd0: if (!is_coin1_detect) begin
          is_coin1_detect <= 1'b1;
          score           <= sat_add(score, COIN_PTS);
        end
        2'd1: if (!is_coin2_detect) begin
          is_coin2_detect <= 1'b1;
          score           <= sat_add(score, COIN_PTS);
        end
        2'd2: if (!is_coin3_detect) begin
          is_coin3_detect <= 1'b1;
          score           <= sat_add(score, COIN_PTS);
        end
        default: begin
`ifdef GOOMBA_EN
          if (!is_goomba1_d1 && snap_fall) score <= sat_add(score, GOOMBA_PTS);
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_score_tracker.sv
module tb_coin_score_tracker;

  // Non-default points/limit so saturation is reachable with three coins and one goomba.
  localparam int CP   = 4;
  localparam int GP   = 5;
  localparam int SMAX = 9;
`ifdef GOOMBA_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] BallX = '0, BallY = '0, Ball_size_X = '0, Ball_size_Y = '0;
  logic [5:0] logx = '0;
  logic       mario_falling = 1'b0;
  logic       is_coin1_detect, is_coin2_detect, is_coin3_detect, is_goomba1_d1;
  logic [9:0] score;
  logic       mario_hit, busy;

  coin_score_tracker #(.COIN_PTS(CP), .GOOMBA_PTS(GP), .SCORE_MAX(SMAX)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .BallX(BallX), .BallY(BallY), .Ball_size_X(Ball_size_X), .Ball_size_Y(Ball_size_Y),
    .logx(logx), .mario_falling(mario_falling),
    .is_coin1_detect(is_coin1_detect), .is_coin2_detect(is_coin2_detect),
    .is_coin3_detect(is_coin3_detect), .is_goomba1_d1(is_goomba1_d1),
    .score(score), .mario_hit(mario_hit), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] flags;     // {goomba, coin3, coin2, coin1} at scan end
    int         score;
    int         busy_len;
    int         hit_cnt;
    int         hit_off;   // busy-relative cycle of mario_hit, -1 if none
    int         c1_off;    // busy-relative cycle coin1 rose, -1 if none
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // Monitor: tracks each scan by busy, compares against the queued expectation when busy drops.
  bit   in_scan = 0;
  bit   c1_prev = 0;
  int   off, len, hcnt, hoff, c1off;
  int   scan_no = 0;
  exp_t e;
  always @(negedge Clk) begin
    if (Reset) begin
      in_scan = 0;
    end else if (busy && !in_scan) begin
      in_scan = 1;
      off = 0; len = 1;
      hcnt  = mario_hit ? 1 : 0;
      hoff  = mario_hit ? 0 : -1;
      c1off = (is_coin1_detect && !c1_prev) ? 0 : -1;
    end else if (busy && in_scan) begin
      off++; len++;
      if (mario_hit) begin hcnt++; hoff = off; end
      if (is_coin1_detect && !c1_prev && c1off < 0) c1off = off;
    end else if (!busy && in_scan) begin
      in_scan = 0;
      scan_no++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_scan %0d: got a scan, expected none", scan_no);
      end else begin
        e = q.pop_front();
        chk($sformatf("scan%0d_flags", scan_no),
            int'({is_goomba1_d1, is_coin3_detect, is_coin2_detect, is_coin1_detect}), int'(e.flags));
        chk($sformatf("scan%0d_score", scan_no), int'(score), e.score);
        chk($sformatf("scan%0d_busy_len", scan_no), len, e.busy_len);
        chk($sformatf("scan%0d_hit_cnt", scan_no), hcnt, e.hit_cnt);
        chk($sformatf("scan%0d_hit_off", scan_no), hoff, e.hit_off);
        chk($sformatf("scan%0d_coin1_off", scan_no), c1off, e.c1_off);
      end
    end
    c1_prev = is_coin1_detect;
  end

  task automatic set_pos(input int bx, input int by, input int sx, input int sy,
                         input int lx, input logic fall);
    BallX = 10'(bx); BallY = 10'(by); Ball_size_X = 10'(sx); Ball_size_Y = 10'(sy);
    logx = 6'(lx); mario_falling = fall;
  endtask

  task automatic push(input logic [3:0] fl, input int sc, input int hc, input int ho, input int c1o);
    exp_t x;
    x.flags = fl; x.score = sc; x.busy_len = 5; x.hit_cnt = hc; x.hit_off = ho; x.c1_off = c1o;
    q.push_back(x);
  endtask

  task automatic pulse_edge();
    @(posedge Clk); #1 frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge Clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scan_timeout: pending %0d expected 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input logic [3:0] fl, input int sc, input int hc, input int ho, input int c1o);
    push(fl, sc, hc, ho, c1o);
    pulse_edge();
    wait_done();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_coin1"}, int'(is_coin1_detect), 0);
    chk({tag, "_coin2"}, int'(is_coin2_detect), 0);
    chk({tag, "_coin3"}, int'(is_coin3_detect), 0);
    chk({tag, "_goomba"}, int'(is_goomba1_d1), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_hit"}, int'(mario_hit), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  logic [3:0] gflag;
  initial gflag = GEN ? 4'b1000 : 4'b0000;

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check_zero("reset");

    // Reset mid-scan: coin1 is awarded, then reset wipes it.
    set_pos(200, 288, 8, 8, 37, 1'b0);
    pulse_edge();
    @(posedge Clk); #1;
    chk("pre_abort_coin1", int'(is_coin1_detect), 1);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check_zero("abort");

    // Coin1 at world X 237: mL=229 mR=245.
    run_frame(4'b0001, 4, 0, -1, 1);
    // Held for three more frames: no re-award.
    for (int i = 0; i < 3; i++) run_frame(4'b0001, 4, 0, -1, -1);

    // Goomba at world X 415, not falling: side hit pulse at N+5 (busy offset 4).
    set_pos(400, 380, 8, 8, 15, 1'b0);
    run_frame(4'b0001, 4, GEN ? 1 : 0, GEN ? 4 : -1, -1);
    // Same place, falling: stomp, 4+5=9.
    set_pos(400, 380, 8, 8, 15, 1'b1);
    run_frame(4'b0001 | gflag, GEN ? 9 : 4, 0, -1, -1);
    // Defeated goomba no longer pulses.
    set_pos(400, 380, 8, 8, 15, 1'b0);
    run_frame(4'b0001 | gflag, GEN ? 9 : 4, 0, -1, -1);

    // Coin2 world X 267, top edge mT=298 touches coin bottom: no hit.
    set_pos(227, 302, 4, 4, 40, 1'b0);
    run_frame(4'b0001 | gflag, GEN ? 9 : 4, 0, -1, -1);
    // One pixel up: overlap, score 8 or saturated 9.
    set_pos(227, 301, 4, 4, 40, 1'b0);
    run_frame(4'b0011 | gflag, GEN ? 9 : 8, 0, -1, -1);
    // Coin3 world X 147: 8+4=12 saturates to 9.
    set_pos(110, 388, 8, 8, 37, 1'b0);
    run_frame(4'b0111 | gflag, 9, 0, -1, -1);

    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check_zero("reset2");

    // Two edges 2 Clk apart with mL exactly 245 (coin1 right edge): one 5-cycle scan, no hit.
    set_pos(209, 288, 4, 4, 40, 1'b0);
    push(4'b0000, 0, 0, -1, -1);
    @(posedge Clk); #1 frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
    @(posedge Clk); #1 frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
    wait_done();
    repeat (8) @(posedge Clk);
    #1;
    chk("double_edge_idle", int'(busy), 0);

    // mR exactly 230 (coin1 left edge): no hit; one pixel right: hit.
    set_pos(186, 288, 4, 4, 40, 1'b0);
    run_frame(4'b0000, 0, 0, -1, -1);
    set_pos(187, 288, 4, 4, 40, 1'b0);
    run_frame(4'b0001, 4, 0, -1, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

endmodule
